exe_stage_sched: RTL and testbench

//  Hazard/stall scheduler for the ID->EXE pipeline register. Generates EXE_Wr/EXE_Flush
//  for the EXE register, plus hold/flush for PC and IF/ID. Handles exception flush,
//  D-cache freeze, multi-cycle DIV occupancy of EXE, and load-use bubbles.

---
 rtl/exe_stage_sched.sv | 144 ++++++++++++++
 tb/tb_exe_stage_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_sched.sv
// Hazard/stall scheduler for the ID->EXE register: exception flush,
// D-cache freeze, multi-cycle divide occupancy and load-use bubbles.
module exe_stage_sched #(
  parameter int DIV_CYCLES = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_Valid,
  input  logic        ID_IsDiv,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic [4:0]  ID_rs,
  input  logic [4:0]  ID_rt,
  input  logic        EXE_IsLoad,
  input  logic [4:0]  EXE_DstReg,
  input  logic        EXE_RegWrEn,
  input  logic        Exc_Flush,
  input  logic        DCache_Busy,
  output logic        EXE_Wr,
  output logic        EXE_Flush,
  output logic        ID_Wr,
  output logic        ID_Flush,
  output logic        PC_Wr,
  output logic        Div_Start,
  output logic        Div_Done,
  output logic        Div_Busy,
  output logic [31:0] Stall_Cnt
);

  localparam int CW = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {
    RUN = 1'b0,
    DIV = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          start_nx;
  logic [31:0]   stall_nx;
  logic          in_div;
  logic          div_hold;
  logic          hazard;
  logic          div_req;
  logic          rs_hit;
  logic          rt_hit;

  assign in_div   = (state == DIV);
  assign div_hold = in_div & (cnt > CNT_ONE);
  assign div_req  = ID_Valid & ID_IsDiv;
  assign rs_hit   = ID_UsesRs & (ID_rs == EXE_DstReg);
  assign rt_hit   = ID_UsesRt & (ID_rt == EXE_DstReg);
  assign hazard   = EXE_IsLoad & EXE_RegWrEn
                  & (EXE_DstReg != 5'd0)
                  & ID_Valid & (rs_hit | rt_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RUN;
      cnt       <= '0;
      Div_Start <= 1'b0;
      Stall_Cnt <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      Div_Start <= start_nx;
      Stall_Cnt <= stall_nx;
    end
  end

  // A freeze during a divide keeps counting down but never releases.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    start_nx = 1'b0;
    stall_nx = Stall_Cnt + {31'd0, ~Exc_Flush & ~PC_Wr};
    priority case (1'b1)
      Exc_Flush: begin
        state_nx = RUN;
        cnt_nx   = '0;
      end
      DCache_Busy: begin
        if (div_hold) cnt_nx = cnt - CNT_ONE;
      end
      div_hold: begin
        cnt_nx = cnt - CNT_ONE;
      end
      default: begin
        if (EXE_Wr & div_req) begin
          state_nx = DIV;
          cnt_nx   = CNT_LOAD;
          start_nx = 1'b1;
        end else begin
          state_nx = RUN;
          cnt_nx   = '0;
        end
      end
    endcase
  end

  always_comb begin
    EXE_Wr    = 1'b0;
    EXE_Flush = 1'b0;
    ID_Wr     = 1'b0;
    ID_Flush  = 1'b0;
    PC_Wr     = 1'b0;
    Div_Done  = 1'b0;
    Div_Busy  = in_div;
    priority case (1'b1)
      !rst: begin
        EXE_Flush = 1'b1;
        ID_Flush  = 1'b1;
        Div_Busy  = 1'b0;
      end
      Exc_Flush: begin
        EXE_Flush = 1'b1;
        ID_Flush  = 1'b1;
        PC_Wr     = 1'b1;
      end
      DCache_Busy, div_hold: begin
        EXE_Wr = 1'b0;
      end
      in_div: begin
        Div_Done = 1'b1;
        EXE_Wr   = 1'b1;
        ID_Wr    = 1'b1;
        PC_Wr    = 1'b1;
      end
      hazard: begin
        EXE_Flush = 1'b1;
      end
      default: begin
        EXE_Wr = 1'b1;
        ID_Wr  = 1'b1;
        PC_Wr  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_exe_stage_sched.sv
// Bench for exe_stage_sched: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_exe_stage_sched;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ID_Valid, ID_IsDiv, ID_UsesRs, ID_UsesRt;
  logic [4:0]  ID_rs, ID_rt, EXE_DstReg;
  logic        EXE_IsLoad, EXE_RegWrEn, Exc_Flush, DCache_Busy;
  logic        EXE_Wr, EXE_Flush, ID_Wr, ID_Flush, PC_Wr;
  logic        Div_Start, Div_Done, Div_Busy;
  logic [31:0] Stall_Cnt;

  exe_stage_sched #(.DIV_CYCLES(N)) dut (
    .clk(clk), .rst(rst),
    .ID_Valid(ID_Valid), .ID_IsDiv(ID_IsDiv),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .ID_rs(ID_rs), .ID_rt(ID_rt),
    .EXE_IsLoad(EXE_IsLoad), .EXE_DstReg(EXE_DstReg),
    .EXE_RegWrEn(EXE_RegWrEn), .Exc_Flush(Exc_Flush),
    .DCache_Busy(DCache_Busy),
    .EXE_Wr(EXE_Wr), .EXE_Flush(EXE_Flush),
    .ID_Wr(ID_Wr), .ID_Flush(ID_Flush), .PC_Wr(PC_Wr),
    .Div_Start(Div_Start), .Div_Done(Div_Done),
    .Div_Busy(Div_Busy), .Stall_Cnt(Stall_Cnt)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  // model: divide in flight, cycles left, start pulse, stall count
  bit          m_div, m_start;
  int          m_left;
  logic [31:0] m_stall;
  bit          e_ewr, e_efl, e_iwr, e_ifl, e_pc, e_done;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit hazard();
    return EXE_IsLoad && EXE_RegWrEn && EXE_DstReg != 0 && ID_Valid &&
           ((ID_UsesRs && ID_rs == EXE_DstReg) ||
            (ID_UsesRt && ID_rt == EXE_DstReg));
  endfunction

  task automatic model_reset();
    m_div = 0; m_left = 0; m_start = 0; m_stall = 0;
  endtask

  task automatic set_exp(input bit ewr, efl, iwr, ifl, pc, dn);
    e_ewr = ewr; e_efl = efl; e_iwr = iwr;
    e_ifl = ifl; e_pc = pc; e_done = dn;
  endtask

  task automatic set_idle();
    ID_Valid = 0; ID_IsDiv = 0; ID_UsesRs = 0; ID_UsesRt = 0;
    ID_rs = 0; ID_rt = 0; EXE_IsLoad = 0; EXE_DstReg = 0;
    EXE_RegWrEn = 0; Exc_Flush = 0; DCache_Busy = 0;
  endtask

  task automatic set_id(input bit v, input bit dv);
    ID_Valid = v; ID_IsDiv = dv;
  endtask

  task automatic check_now();
    #2;
    if (!rst) model_reset();
    if (!rst)                               set_exp(0, 1, 0, 1, 0, 0);
    else if (Exc_Flush)                     set_exp(0, 1, 0, 1, 1, 0);
    else if (DCache_Busy)                   set_exp(0, 0, 0, 0, 0, 0);
    else if (m_div && m_left > 1)           set_exp(0, 0, 0, 0, 0, 0);
    else if (m_div)                         set_exp(1, 0, 1, 0, 1, 1);
    else if (hazard())                      set_exp(0, 1, 0, 0, 0, 0);
    else                                    set_exp(1, 0, 1, 0, 1, 0);
    chk("EXE_Wr", 32'(EXE_Wr), 32'(e_ewr));
    chk("EXE_Flush", 32'(EXE_Flush), 32'(e_efl));
    chk("ID_Wr", 32'(ID_Wr), 32'(e_iwr));
    chk("ID_Flush", 32'(ID_Flush), 32'(e_ifl));
    chk("PC_Wr", 32'(PC_Wr), 32'(e_pc));
    chk("Div_Done", 32'(Div_Done), 32'(e_done));
    chk("Div_Busy", 32'(Div_Busy), 32'(rst && m_div));
    chk("Div_Start", 32'(Div_Start), 32'(m_start));
    chk("Stall_Cnt", Stall_Cnt, m_stall);
  endtask

  task automatic advance();
    bit enter;
    if (!rst) model_reset();
    else begin
      if (!Exc_Flush && !e_pc) m_stall = m_stall + 1;
      enter = e_ewr && ID_Valid && ID_IsDiv;
      if (Exc_Flush) begin
        m_div = 0; m_left = 0; m_start = 0;
      end else if (DCache_Busy) begin
        if (m_div && m_left > 1) m_left--;
        m_start = 0;
      end else if (m_div && m_left > 1) begin
        m_left--; m_start = 0;
      end else if (enter) begin
        m_div = 1; m_left = N; m_start = 1;
      end else begin
        m_div = 0; m_left = 0; m_start = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    model_reset();
    #1;
    chk("rst_EXE_Flush", 32'(EXE_Flush), 32'd1);
    chk("rst_ID_Flush", 32'(ID_Flush), 32'd1);
    chk("rst_EXE_Wr", 32'(EXE_Wr), 32'd0);
    chk("rst_PC_Wr", 32'(PC_Wr), 32'd0);
    chk("rst_Div_Busy", 32'(Div_Busy), 32'd0);
    chk("rst_Stall", Stall_Cnt, 32'd0);
    @(negedge clk);
    rst = 1;

    check_now();
    chk("norm_EXE_Wr", 32'(EXE_Wr), 32'd1);
    advance();

    // load-use on r5
    EXE_IsLoad = 1; EXE_RegWrEn = 1; EXE_DstReg = 5;
    set_id(1, 0); ID_UsesRs = 1; ID_rs = 5;
    check_now();
    chk("lu_EXE_Flush", 32'(EXE_Flush), 32'd1);
    chk("lu_PC_Wr", 32'(PC_Wr), 32'd0);
    chk("lu_ID_Wr", 32'(ID_Wr), 32'd0);
    advance();
    EXE_IsLoad = 0; EXE_RegWrEn = 0; EXE_DstReg = 0;
    check_now();
    chk("lu_next_EXE_Wr", 32'(EXE_Wr), 32'd1);
    chk("lu_Stall", Stall_Cnt, 32'd1);
    advance();

    // load to $0 never stalls
    EXE_IsLoad = 1; EXE_RegWrEn = 1; EXE_DstReg = 0; ID_rs = 0;
    check_now();
    chk("lu0_EXE_Wr", 32'(EXE_Wr), 32'd1);
    advance();
    set_idle();

    // single divide
    set_id(1, 1);
    check_now();
    advance();
    set_id(1, 0);
    for (int k = 1; k <= 3; k++) begin
      check_now();
      chk("div_EXE_Wr", 32'(EXE_Wr), 32'd0);
      chk("div_Start", 32'(Div_Start), 32'(k == 1));
      advance();
    end
    check_now();
    chk("div_Done", 32'(Div_Done), 32'd1);
    chk("div_rel_EXE_Wr", 32'(EXE_Wr), 32'd1);
    chk("div_Stall", Stall_Cnt, 32'd4);
    advance();
    check_now();
    chk("div_after_Busy", 32'(Div_Busy), 32'd0);
    advance();

    // back-to-back divides
    set_id(1, 1);
    check_now();
    advance();
    set_id(1, 0);
    repeat (3) begin check_now(); advance(); end
    set_id(1, 1);
    check_now();
    chk("b2b_Done", 32'(Div_Done), 32'd1);
    advance();
    set_id(1, 0);
    check_now();
    chk("b2b_Start", 32'(Div_Start), 32'd1);
    chk("b2b_Busy", 32'(Div_Busy), 32'd1);
    advance();
    repeat (3) begin check_now(); advance(); end

    // freeze mid-divide at cnt=3 for 5 cycles
    set_id(1, 1);
    check_now();
    advance();
    set_id(1, 0);
    check_now();
    advance();
    DCache_Busy = 1;
    repeat (5) begin
      check_now();
      chk("frz_Done", 32'(Div_Done), 32'd0);
      chk("frz_EXE_Wr", 32'(EXE_Wr), 32'd0);
      advance();
    end
    DCache_Busy = 0;
    check_now();
    chk("frz_rel_Done", 32'(Div_Done), 32'd1);
    advance();

    // exception with freeze at cnt=2
    set_id(1, 1);
    check_now();
    advance();
    set_id(1, 0);
    repeat (2) begin check_now(); advance(); end
    Exc_Flush = 1; DCache_Busy = 1;
    check_now();
    chk("exc_EXE_Flush", 32'(EXE_Flush), 32'd1);
    chk("exc_ID_Flush", 32'(ID_Flush), 32'd1);
    chk("exc_PC_Wr", 32'(PC_Wr), 32'd1);
    chk("exc_EXE_Wr", 32'(EXE_Wr), 32'd0);
    advance();
    Exc_Flush = 0; DCache_Busy = 0;
    check_now();
    chk("exc_after_Busy", 32'(Div_Busy), 32'd0);
    chk("exc_after_EXE_Wr", 32'(EXE_Wr), 32'd1);
    advance();

    // async reset in the middle of a divide
    set_id(1, 1);
    check_now();
    advance();
    set_id(1, 0);
    check_now();
    rst = 0;
    #1;
    chk("arst_EXE_Flush", 32'(EXE_Flush), 32'd1);
    chk("arst_PC_Wr", 32'(PC_Wr), 32'd0);
    chk("arst_Div_Busy", 32'(Div_Busy), 32'd0);
    chk("arst_Div_Start", 32'(Div_Start), 32'd0);
    chk("arst_Stall", Stall_Cnt, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 299) != 0);
      ID_Valid    = ($urandom_range(0, 7) != 0);
      ID_IsDiv    = ($urandom_range(0, 5) == 0);
      ID_UsesRs   = $urandom_range(0, 1);
      ID_UsesRt   = $urandom_range(0, 1);
      ID_rs       = 5'($urandom_range(0, 3));
      ID_rt       = 5'($urandom_range(0, 3));
      EXE_IsLoad  = ($urandom_range(0, 2) == 0);
      EXE_DstReg  = 5'($urandom_range(0, 3));
      EXE_RegWrEn = ($urandom_range(0, 3) != 0);
      Exc_Flush   = ($urandom_range(0, 39) == 0);
      DCache_Busy = ($urandom_range(0, 7) == 0);
      check_now();
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
